// File: rtl/mul_div_unit_if.sv
// Request/result bus between the ALU control decode and the iterative mul/div engine.
// The core drives the master side; the engine implements the slave side.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       ALU_control;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, ALU_control, SrcA, SrcB,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, ALU_control, SrcA, SrcB,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in a single FIX cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   abs_a_q, abs_b_q;
  logic               is_div_q, sign_a_q, sign_b_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;

  logic               code_ok, is_div_req, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [2*WIDTH-1:0] prod_signed;

  assign code_ok    = (bus.ALU_control == OP_MUL) || (bus.ALU_control == OP_DIV);
  assign is_div_req = (bus.ALU_control == OP_DIV);
  assign accept     = bus.start && code_ok && ((state_q == IDLE) || (state_q == DONE));
  assign abs_a      = bus.SrcA[WIDTH-1] ? -bus.SrcA : bus.SrcA;
  assign abs_b      = bus.SrcB[WIDTH-1] ? -bus.SrcB : bus.SrcB;

  // acc_q holds {partial product, remaining multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, abs_a_q} : {(WIDTH+1){1'b0}});
    div_shift    = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge       = div_shift >= {1'b0, abs_b_q};
    div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, abs_b_q}) : div_shift[WIDTH-1:0];
    if (is_div_q) begin
      acc_d = {div_rem_next, acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_signed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    if (!is_div_q) begin
      {hi_d, lo_d} = prod_signed;
    end else if (div_zero_q) begin
      hi_d = sign_a_q ? -abs_a_q : abs_a_q;
      lo_d = {WIDTH{1'b1}};
    end else begin
      hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      abs_a_q    <= '0;
      abs_b_q    <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q    <= CALC;
            cnt_q      <= CNT_W'(WIDTH);
            busy_q     <= 1'b1;
            is_div_q   <= is_div_req;
            abs_a_q    <= abs_a;
            abs_b_q    <= abs_b;
            sign_a_q   <= bus.SrcA[WIDTH-1];
            sign_b_q   <= bus.SrcB[WIDTH-1];
            div_zero_q <= is_div_req && (bus.SrcB == '0);
            acc_q      <= is_div_req ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule
